// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: packet-granular two-producer write arbiter for the shared UART TX FIFO
// Ports: clk, reset (sync, active-low); req0/data0/last0/ack0 and req1/data1/last1/ack1
// producer handshakes; fifo_full in, fifo_wr/fifo_wdata out; gnt one-hot grant, busy.
// Optional macro ARB_FIXED_PRIO_EN: ties in IDLE always go to requester 0.
module tx_fifo_arbiter #(
   parameter int B  = 8,
   parameter int CW = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [B-1:0] data0,
   input  logic         last0,
   output logic         ack0,
   input  logic         req1,
   input  logic [B-1:0] data1,
   input  logic         last1,
   output logic         ack1,
   input  logic         fifo_full,
   output logic         fifo_wr,
   output logic [B-1:0] fifo_wdata,
   output logic [1:0]   gnt,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, G0, G1} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic sel_req, sel_last, done;
`ifndef ARB_FIXED_PRIO_EN
   logic last_gnt, last_gnt_nx;
`endif
   always_comb begin
      sel_req    = (state == G0) ? req0 : (state == G1) ? req1 : 1'b0;
      sel_last   = (state == G1) ? last1 : last0;
      fifo_wr    = sel_req & ~fifo_full;
      fifo_wdata = (state == G0) ? data0 : (state == G1) ? data1 : '0;
      ack0       = fifo_wr & (state == G0);
      ack1       = fifo_wr & (state == G1);
      gnt        = {state == G1, state == G0};
      busy       = state != IDLE;
      // all-ones count means this transfer is word MAXBURST of the grant
      done       = ~sel_req | (fifo_wr & (sel_last | (&cnt)));
      state_nx   = state;
      cnt_nx     = cnt;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_nx = last_gnt;
`endif
      if (state == IDLE) begin
`ifdef ARB_FIXED_PRIO_EN
         state_nx = req0 ? G0 : req1 ? G1 : IDLE;
`else
         // last_gnt=1 means requester 1 was served last, so 0 wins a tie
         state_nx = (req0 & req1) ? (last_gnt ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
`endif
      end else if (done) begin
         state_nx = IDLE;
         cnt_nx   = '0;
`ifndef ARB_FIXED_PRIO_EN
         last_gnt_nx = state == G1;
`endif
      end else if (fifo_wr) begin
         cnt_nx = cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
         last_gnt <= 1'b1;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
`ifndef ARB_FIXED_PRIO_EN
         last_gnt <= last_gnt_nx;
`endif
      end
   end
endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: randomized bench for tx_fifo_arbiter against a packet-level reference model
module tb_tx_fifo_arbiter;
   localparam int MAXB = 16;
   logic clk = 0, reset = 0, req0 = 0, last0 = 0, req1 = 0, last1 = 0, fifo_full = 0;
   logic [7:0] data0 = 0, data1 = 0, fifo_wdata;
   logic ack0, ack1, fifo_wr, busy;
   logic [1:0] gnt;
   int vectors = 0, miscompares = 0;
   logic [8:0] q0[$], q1[$];
   int log_own[$];
   logic [7:0] log_dat[$];
   int m_own = -1, m_last = 1, m_words = 0;
   logic en0 = 1, en1 = 1;

   always #5 clk = ~clk;

   tx_fifo_arbiter #(.B(8), .CW(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
      .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
      .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
      .gnt(gnt), .busy(busy)
   );

   task automatic add_pkt(input int who, input int n, input int base);
      logic [8:0] w;
      for (int i = 0; i < n; i++) begin
         w = {i == n - 1, 8'(base + i)};
         if (who == 0) q0.push_back(w); else q1.push_back(w);
      end
   endtask

   // one clock: producers present queue heads, model predicts outputs, clock advances
   task automatic cycle(output logic [13:0] got, output logic [13:0] exp);
      logic ew;
      logic [7:0] ed;
      logic [8:0] tmp;
      logic r[2], l[2];
      logic [7:0] d[2];
      req0  = en0 && (q0.size() > 0);
      data0 = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
      last0 = (q0.size() > 0) ? q0[0][8] : 1'($urandom);
      req1  = en1 && (q1.size() > 0);
      data1 = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
      last1 = (q1.size() > 0) ? q1[0][8] : 1'($urandom);
      r = '{req0, req1};
      l = '{last0, last1};
      d = '{data0, data1};
      ew = 0;
      ed = 0;
      if (m_own >= 0) begin
         ew = r[m_own] && !fifo_full;
         ed = d[m_own];
      end
      exp = {m_own == 1, m_own == 0, m_own >= 0, ew && m_own == 1, ew && m_own == 0, ew, ed};
      #1 got = {gnt, busy, ack1, ack0, fifo_wr, fifo_wdata};
      @(posedge clk);
      if (ew) begin
         log_own.push_back(m_own);
         log_dat.push_back(ed);
         if (m_own == 0) tmp = q0.pop_front(); else tmp = q1.pop_front();
      end
      if (!reset) begin
         m_own = -1; m_last = 1; m_words = 0;
      end else if (m_own < 0) begin
`ifdef ARB_FIXED_PRIO_EN
         if (r[0]) m_own = 0; else if (r[1]) m_own = 1;
`else
         if (r[0] && r[1]) m_own = 1 - m_last; else if (r[0]) m_own = 0; else if (r[1]) m_own = 1;
`endif
      end else if (!r[m_own] || (ew && (l[m_own] || m_words == MAXB - 1))) begin
         m_last = m_own; m_own = -1; m_words = 0;
      end else if (ew) begin
         m_words++;
      end
      @(negedge clk);
   endtask

   task automatic init();
      logic [13:0] g, e;
      q0.delete(); q1.delete(); log_own.delete(); log_dat.delete();
      en0 = 1; en1 = 1; fifo_full = 0; reset = 0;
      cycle(g, e);
      cycle(g, e);
      reset = 1;
   endtask

   task automatic test_reset();
      logic [13:0] g, e;
      init();
      reset = 0;
      add_pkt(0, 4, 'h30);
      add_pkt(1, 4, 'h40);
      for (int i = 0; i < 4; i++) begin
         cycle(g, e);
         vectors++;
         if (g !== e || g !== 14'h0) begin
            miscompares++;
            $display("FAIL reset cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      reset = 1;
   endtask

   task automatic test_single();
      logic [13:0] g, e;
      init();
      reset = 0;
      add_pkt(0, 1, 'h41);
      cycle(g, e);
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         cycle(g, e);
         vectors++;
         if (g !== e || (i == 1 && g !== {2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41})) begin
            miscompares++;
            $display("FAIL single cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_dat.size() != 1 || log_dat[0] !== 8'h41) begin
         miscompares++;
         $display("FAIL single_log got=%0d words exp=1 word 41", log_dat.size());
      end
   endtask

   task automatic test_tie();
      logic [13:0] g, e;
      logic [7:0] want[6];
      want = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
      init();
      add_pkt(0, 3, 'hA0);
      add_pkt(1, 3, 'hB0);
      for (int i = 0; i < 10; i++) begin
         cycle(g, e);
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL tie cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_dat.size() != 6) begin
         miscompares++;
         $display("FAIL tie_count got=%0d exp=6", log_dat.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            vectors++;
            if (log_dat[i] !== want[i]) begin
               miscompares++;
               $display("FAIL tie_order idx%0d got=%h exp=%h", i, log_dat[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_full();
      logic [13:0] g, e;
      init();
      fifo_full = 1;
      add_pkt(1, 1, 'h55);
      for (int i = 0; i < 9; i++) begin
         if (i == 6) fifo_full = 0;
         cycle(g, e);
         vectors++;
         if (g !== e || (i >= 1 && i <= 5 && g[13:8] !== 6'b101000)) begin
            miscompares++;
            $display("FAIL full cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_dat.size() != 1 || log_dat[0] !== 8'h55 || log_own[0] != 1) begin
         miscompares++;
         $display("FAIL full_log got=%0d words exp=1 word 55 from 1", log_dat.size());
      end
   endtask

   task automatic test_burst();
      logic [13:0] g, e;
      logic [7:0] want[$];
      init();
      add_pkt(0, 20, 1);
      add_pkt(1, 3, 'hC0);
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 1; i <= 20; i++) want.push_back(8'(i));
      for (int i = 0; i < 3; i++) want.push_back(8'('hC0 + i));
`else
      for (int i = 1; i <= 16; i++) want.push_back(8'(i));
      for (int i = 0; i < 3; i++) want.push_back(8'('hC0 + i));
      for (int i = 17; i <= 20; i++) want.push_back(8'(i));
`endif
      for (int i = 0; i < 40; i++) begin
         cycle(g, e);
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL burst cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_dat.size() != 23) begin
         miscompares++;
         $display("FAIL burst_count got=%0d exp=23", log_dat.size());
      end else begin
         for (int i = 0; i < 23; i++) begin
            vectors++;
            if (log_dat[i] !== want[i]) begin
               miscompares++;
               $display("FAIL burst_order idx%0d got=%h exp=%h", i, log_dat[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      logic [13:0] g, e;
      init();
      add_pkt(0, 5, 'h10);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) en0 = 0;
         cycle(g, e);
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL abort cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_dat.size() != 2) begin
         miscompares++;
         $display("FAIL abort_count got=%0d exp=2", log_dat.size());
      end
      q0.delete();
      en0 = 1;
      add_pkt(1, 6, 'h20);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) reset = 0;
         if (i == 4) reset = 1;
         cycle(g, e);
         vectors++;
         if (g !== e || (i == 4 && g !== 14'h0)) begin
            miscompares++;
            $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      q1.delete();
   endtask

   task automatic test_prio();
      logic [13:0] g, e;
      init();
      for (int i = 0; i < 8; i++) begin
         add_pkt(0, 1, 'h60 + i);
         add_pkt(1, 1, 'h70 + i);
      end
      for (int i = 0; i < 12; i++) begin
         cycle(g, e);
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL prio cyc%0d got=%h exp=%h", i, g, e);
         end
      end
      vectors++;
      if (log_own.size() != 6) begin
         miscompares++;
         $display("FAIL prio_count got=%0d exp=6", log_own.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            int want = 0;
`else
            int want = i % 2;
`endif
            vectors++;
            if (log_own[i] != want) begin
               miscompares++;
               $display("FAIL prio_owner idx%0d got=%0d exp=%0d", i, log_own[i], want);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [13:0] g, e;
      init();
      for (int i = 0; i < 600; i++) begin
         if (q0.size() == 0 && $urandom_range(0, 3) == 0) add_pkt(0, $urandom_range(1, 20), $urandom);
         if (q1.size() == 0 && $urandom_range(0, 3) == 0) add_pkt(1, $urandom_range(1, 20), $urandom);
         fifo_full = $urandom_range(0, 3) == 0;
         en0 = $urandom_range(0, 15) != 0;
         en1 = $urandom_range(0, 15) != 0;
         cycle(g, e);
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL random cyc%0d got=%h exp=%h", i, g, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_full();
      test_burst();
      test_abort();
      test_prio();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
Write-side arbiter for the shared UART transmit FIFO (B-bit words, full/empty flags, write ignored when full).
- Lets two producers (for example, a command echo path and a status reporter) share the single FIFO write port.
- Grants whole packets, so bytes from different producers never interleave.
- Rotates fairly between producers and caps burst length so neither can starve the other.

Parameters:
B, 8, data word width; must match the FIFO word width.
CW, 4, burst counter width; maximum words per grant is MAXBURST = 2**CW.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset.
req0  input  1  requester 0 has a word on data0.
data0  input  B  requester 0 write data.
last0  input  1  data0 is the final word of requester 0's packet.
ack0  output  1  data0 accepted this cycle.
req1  input  1  requester 1 has a word on data1.
data1  input  B  requester 1 write data.
last1  input  1  data1 is the final word of requester 1's packet.
ack1  output  1  data1 accepted this cycle.
fifo_full  input  1  FIFO full flag.
fifo_wr  output  1  FIFO write strobe.
fifo_wdata  output  B  FIFO write data.
gnt  output  2  one-hot current grant; 00 when idle.
busy  output  1  a grant is active.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, cnt=0, last_gnt=1 (requester 0 wins the first tie).
  - Outputs: gnt=00, busy=0, ack0=ack1=0, fifo_wr=0, fifo_wdata=0.
  - Reset asserted mid-packet drops the grant immediately. Words already written stay in the FIFO.
- States: IDLE, G0, G1.
- IDLE:
  - Only req0 high -> G0. Only req1 high -> G1.
  - Both high -> grant the requester that is NOT last_gnt.
  - Neither high -> stay in IDLE.
  - No writes occur in IDLE. Arbitration latency is 1 cycle from req to gnt.
- Gx, combinational outputs:
  - fifo_wr = reqx & ~fifo_full.
  - fifo_wdata = datax.
  - ackx = fifo_wr. The other ack is 0.
  - gnt[x]=1, busy=1.
- Transfer: a cycle with ackx=1 moves one word. The requester presents the next word or drops req in the following cycle.
- Full handling: fifo_wr never asserts while fifo_full=1. The grant is held and the word waits with no loss.
- Gx exits to IDLE (cnt<=0, last_gnt<=x) on any of:
  - (a) a transfer with lastx=1.
  - (b) a transfer with cnt==MAXBURST-1 (forced release; the packet resumes on a later grant).
  - (c) reqx==0 (abort, no write).
- Otherwise a transfer increments cnt. cnt wraps only through the reset-to-0 on exit.
- Throughput: a sustained single requester achieves 1 word per cycle inside a grant. Each grant costs 1 idle arbitration cycle.
- Data muxing: fifo_wdata=0 in IDLE. Inputs of the non-granted requester are ignored entirely.
- last0/last1 are sampled only on a transfer cycle.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: tie in IDLE always grants requester 0; last_gnt is unused. The burst cap (b) still applies.
- Undefined: round-robin tie break as described in Behaviour.

Test Plan:
- Reset release with req0=1, data0=8'h41, last0=1, fifo_full=0 -> gnt=01 one cycle later; fifo_wr=1, ack0=1, fifo_wdata=8'h41 for exactly 1 cycle; then IDLE.
- req0 and req1 both asserted from IDLE, each sending 3-word packets (last on the 3rd) -> order is G0 (3 writes), IDLE, G1 (3 writes); all of requester 0's words precede requester 1's, no interleave.
- G1 active, word 8'h55, fifo_full=1 for 5 cycles -> fifo_wr=0, ack1=0 throughout, gnt held at 10; fifo_full drops -> single write of 8'h55.
- CW=4, requester 0 sends 20 words with last0 only on the 20th, req1 held high -> exactly 16 writes, then G1 serves its packet, then G0 resumes with words 17-20.
- req0 dropped mid-packet after 2 words -> IDLE next cycle, no extra write; reset pulled low mid-G1 -> all outputs 0 on the next edge.
- ARB_FIXED_PRIO_EN defined, both requesting single-word packets continuously -> only requester 0 is ever granted.
